fpga_boot_sequencer: RTL
========================

# fpga_boot_sequencer

Reset and boot-strap sequencer for the FPGA x_heep_system instance. It takes start and abort requests from the PS GPIO bank (or board buttons) and produces a controlled sequence on the system reset, boot_select, execute_from_flash and JTAG TRST straps. It then watches exit_valid/exit_value and latches the program result for the PS to read back. It sits in the FPGA wrapper between the clock wizard/PS wrapper and x_heep_system.

## Interface
Parameters:
- RST_HOLD_CYCLES, default 16: cycles sys_rst_no is held low in ASSERT; legal range ≥1.
- BOOT_SETTLE_CYCLES, default 4: cycles in RELEASE before entering RUN; legal range ≥1.
- TIMEOUT_CYCLES, default 2**24: RUN watchdog limit; only used when BOOT_WATCHDOG_EN is defined.

Ports:
- clk_gen, in, 1: system clock from the clock wizard.
- rst_n, in, 1: asynchronous, active-low reset.
- start_i, in, 1: boot request level, asynchronous to clk_gen (PS domain).
- abort_i, in, 1: abort request level, asynchronous to clk_gen.
- boot_mode_i, in, 2: bit0 = boot_select, bit1 = execute_from_flash; quasi-static.
- exit_valid_i, in, 1: exit_valid from x_heep_system.
- exit_value_i, in, 32: exit_value from x_heep_system.
- sys_rst_no, out, 1: active-low reset to x_heep_system.
- jtag_trst_no, out, 1: active-low JTAG TRST.
- boot_select_o, out, 1: boot_select strap.
- execute_from_flash_o, out, 1: execute_from_flash strap.
- busy_o, out, 1: high in ASSERT, RELEASE and RUN.
- done_o, out, 1: high in DONE.
- timeout_o, out, 1: high when the run ended by watchdog.
- exit_value_o, out, 32: latched result.
- state_o, out, 3: current state encoding, for debug and ILA.

## Operation
- start_i, abort_i and boot_mode_i each pass through a 2-flop synchronizer. A start is the rising edge of synchronized start.
- States:
  - IDLE: sys_rst_no=0, jtag_trst_no=0, straps=0. A start edge latches boot_mode, clears done_o, timeout_o and exit_value_o, loads the counter with RST_HOLD_CYCLES-1, and moves to ASSERT.
  - ASSERT: sys_rst_no=0, jtag_trst_no=0, straps driven from the latched mode. At counter==0, load BOOT_SETTLE_CYCLES-1 and move to RELEASE.
  - RELEASE: sys_rst_no=1, jtag_trst_no=1, straps held. At counter==0, move to RUN; the watchdog counter is cleared.
  - RUN: exit_valid_i=1 latches exit_value_i in that cycle and moves to DONE.
  - DONE: sys_rst_no stays 1 and straps stay held. A start edge moves to ASSERT, with the same clearing as from IDLE.
- Abort: synchronized abort_i=1 in any state moves to IDLE next cycle. It takes priority over start edges, exit_valid_i and the watchdog. Latched results are kept.
- A start edge in ASSERT, RELEASE or RUN is ignored.
- Counting: one shared down-counter, width $clog2 of the largest limit in use.
- State encoding: IDLE=0, ASSERT=1, RELEASE=2, RUN=3, DONE=4.

## Timing
- Reset values:
  - sys_rst_no=0, jtag_trst_no=0, boot_select_o=0, execute_from_flash_o=0.
  - busy_o=0, done_o=0, timeout_o=0, exit_value_o=0, state_o=IDLE.
- All outputs are registered.
- Start latency: start_i sampled high at edge N gives state ASSERT after edge N+3; busy_o=1 from that point.
- sys_rst_no is low for exactly RST_HOLD_CYCLES cycles in ASSERT.
- RELEASE lasts exactly BOOT_SETTLE_CYCLES cycles.
- exit_valid_i sampled at edge M gives done_o=1 and a valid exit_value_o after edge M.
- Abort latency is 3 edges from abort_i, analogous to start.
- Asserting rst_n mid-run returns everything to the reset values asynchronously.

## Configuration
- BOOT_WATCHDOG_EN defined:
  - The RUN counter counts up. When it reaches TIMEOUT_CYCLES-1 with exit_valid_i=0, the block moves to DONE with timeout_o=1 and exit_value_o=32'hFFFF_FFFF.
  - If exit_valid_i=1 in the same cycle, exit wins: timeout_o=0 and the real value is latched.
- BOOT_WATCHDOG_EN undefined: no watchdog logic, timeout_o tied 0, RUN waits indefinitely.

## Structure
- Package fpga_boot_seq_pkg holds:
  - the state enum boot_state_e (3 bits);
  - the boot_mode_t packed struct {execute_from_flash, boot_select};
  - the constant TIMEOUT_VALUE = 32'hFFFF_FFFF.
- Sub-module fpga_boot_seq_sync: parameterized-width 2-flop synchronizer with async reset to 0. It is instantiated for start_i, abort_i and boot_mode_i.

## Test plan
- Reset, then start_i=1 with boot_mode_i=2'b01 →
  - ASSERT after 3 edges;
  - sys_rst_no low for 16 cycles, then jtag_trst_no=1 with sys_rst_no;
  - boot_select_o=1 and execute_from_flash_o=0 throughout;
  - RUN 4 cycles after release.
- In RUN, exit_valid_i=1 with exit_value_i=32'h0000_0000 → done_o=1 next edge, exit_value_o=0, busy_o=0; a later exit_value_i change does not alter exit_value_o.
- Abort in RELEASE → IDLE 3 edges after abort_i; sys_rst_no=0, straps=0; a start edge held during the abort is ignored.
- From DONE (exit_value_o=32'h1), toggle start_i → done_o and exit_value_o cleared, full sequence repeats.
- With BOOT_WATCHDOG_EN and TIMEOUT_CYCLES=100, no exit_valid_i → after 100 RUN cycles timeout_o=1 and exit_value_o=32'hFFFF_FFFF. A repeat run with exit_valid_i=1 exactly at cycle 100 gives timeout_o=0 and the real value.
- Deassert rst_n during RUN → all outputs return to reset values immediately; no spurious start after rst_n is released while start_i is held high.

Source files
------------

// File: rtl/fpga_boot_seq_pkg.sv
// ----------------------------------------------------------------------------
// fpga_boot_seq_pkg
// Shared types and constants for the FPGA boot sequencer slice.
//   boot_state_e  : 3-bit state encoding exported on state_o
//   boot_mode_t   : {execute_from_flash, boot_select}, bit order of boot_mode_i
//   TIMEOUT_VALUE : result reported when the RUN watchdog fires
//   max_u         : helper used for sizing the shared counter
// ----------------------------------------------------------------------------
package fpga_boot_seq_pkg;

    typedef enum logic [2:0] {
        BOOT_IDLE    = 3'd0,
        BOOT_ASSERT  = 3'd1,
        BOOT_RELEASE = 3'd2,
        BOOT_RUN     = 3'd3,
        BOOT_DONE    = 3'd4
    } boot_state_e;

    typedef struct packed {
        logic execute_from_flash;
        logic boot_select;
    } boot_mode_t;

    localparam logic [31:0] TIMEOUT_VALUE = 32'hFFFF_FFFF;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fpga_boot_seq_sync.sv
// ----------------------------------------------------------------------------
// fpga_boot_seq_sync
// Parameterized-width two-flop synchronizer with asynchronous active-low reset
// to zero. Each bit is synchronized independently, so multi-bit inputs must be
// quasi-static.
// Ports:
//   clk_gen    : destination clock
//   rst_n      : asynchronous active-low reset
//   data_async : input from the foreign clock domain
//   data_sync  : synchronized copy, two clk_gen edges later
// ----------------------------------------------------------------------------
module fpga_boot_seq_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_gen,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_async,
    output logic [WIDTH-1:0] data_sync
);

    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            meta_q    <= '0;
            data_sync <= '0;
        end else begin
            meta_q    <= data_async;
            data_sync <= meta_q;
        end
    end

endmodule

// File: rtl/fpga_boot_sequencer.sv
// ----------------------------------------------------------------------------
// fpga_boot_sequencer
// Reset and boot-strap sequencer for the FPGA x_heep_system instance.
// Sequence: IDLE -> ASSERT (reset held) -> RELEASE (settle) -> RUN -> DONE.
// Optional feature macro: BOOT_WATCHDOG_EN (RUN watchdog, TIMEOUT_CYCLES).
// Ports:
//   clk_gen, rst_n          : clock and asynchronous active-low reset
//   start_i, abort_i        : asynchronous request levels from the PS
//   boot_mode_i             : {execute_from_flash, boot_select}, quasi-static
//   exit_valid_i/value_i    : program exit report from x_heep_system
//   sys_rst_no, jtag_trst_no: active-low resets to x_heep_system
//   boot_select_o,
//   execute_from_flash_o    : boot straps
//   busy_o, done_o,
//   timeout_o, exit_value_o : status and latched result
//   state_o                 : current state encoding for debug/ILA
// ----------------------------------------------------------------------------
module fpga_boot_sequencer
    import fpga_boot_seq_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES    = 16,
    parameter int unsigned BOOT_SETTLE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES     = 2**24
) (
    input  logic        clk_gen,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [1:0]  boot_mode_i,
    input  logic        exit_valid_i,
    input  logic [31:0] exit_value_i,
    output logic        sys_rst_no,
    output logic        jtag_trst_no,
    output logic        boot_select_o,
    output logic        execute_from_flash_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic [31:0] exit_value_o,
    output logic [2:0]  state_o
);

    localparam logic [2:0] ST_IDLE    = 3'(BOOT_IDLE);
    localparam logic [2:0] ST_ASSERT  = 3'(BOOT_ASSERT);
    localparam logic [2:0] ST_RELEASE = 3'(BOOT_RELEASE);
    localparam logic [2:0] ST_RUN     = 3'(BOOT_RUN);
    localparam logic [2:0] ST_DONE    = 3'(BOOT_DONE);

    // The shared counter only has to hold (limit - 1) of the limits in use.
    localparam int unsigned SEQ_MAX = max_u(RST_HOLD_CYCLES, BOOT_SETTLE_CYCLES);
`ifdef BOOT_WATCHDOG_EN
    localparam int unsigned CNT_MAX = max_u(SEQ_MAX, TIMEOUT_CYCLES);
`else
    localparam int unsigned CNT_MAX = SEQ_MAX;
`endif
    localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic             start_sync;
    logic             abort_sync;
    logic [1:0]       mode_sync;
    logic [1:0]       warm_q;
    logic             start_d;
    logic             start_armed;
    logic             start_pulse;
    logic             abort_q;

    logic [2:0]       state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    boot_mode_t       mode_q, mode_nxt;
    logic [31:0]      result_nxt;
    logic             timeout_nxt;

    fpga_boot_seq_sync #(.WIDTH(1)) u_start_sync (
        .clk_gen    (clk_gen),
        .rst_n      (rst_n),
        .data_async (start_i),
        .data_sync  (start_sync)
    );

    fpga_boot_seq_sync #(.WIDTH(1)) u_abort_sync (
        .clk_gen    (clk_gen),
        .rst_n      (rst_n),
        .data_async (abort_i),
        .data_sync  (abort_sync)
    );

    fpga_boot_seq_sync #(.WIDTH(2)) u_mode_sync (
        .clk_gen    (clk_gen),
        .rst_n      (rst_n),
        .data_async (boot_mode_i),
        .data_sync  (mode_sync)
    );

    // Request front end. The synchronizer outputs are only trusted once warm_q
    // has filled; a start edge is accepted only after start has been seen low
    // in that trusted window, so a start_i held high across reset never
    // launches a boot. Edge and abort are registered once more, giving the
    // three-edge request latency.
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            warm_q      <= '0;
            start_d     <= 1'b0;
            start_armed <= 1'b0;
            start_pulse <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            warm_q      <= {warm_q[0], 1'b1};
            start_d     <= start_sync;
            if (warm_q[1] && !start_sync) begin
                start_armed <= 1'b1;
            end
            start_pulse <= start_armed && start_sync && !start_d;
            abort_q     <= abort_sync;
        end
    end

    // Next-state logic. Abort overrides everything; results are only cleared
    // when a new boot is launched.
    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        mode_nxt    = mode_q;
        result_nxt  = exit_value_o;
        timeout_nxt = timeout_o;
        if (abort_q) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_pulse) begin
                        state_nxt   = ST_ASSERT;
                        mode_nxt    = boot_mode_t'(mode_sync);
                        result_nxt  = '0;
                        timeout_nxt = 1'b0;
                        cnt_nxt     = CNT_W'(RST_HOLD_CYCLES - 1);
                    end
                end
                ST_ASSERT: begin
                    if (cnt_q == '0) begin
                        state_nxt = ST_RELEASE;
                        cnt_nxt   = CNT_W'(BOOT_SETTLE_CYCLES - 1);
                    end else begin
                        cnt_nxt = cnt_q - CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == '0) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_q - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    // A real exit in the watchdog's final cycle still wins.
                    if (exit_valid_i) begin
                        state_nxt  = ST_DONE;
                        result_nxt = exit_value_i;
                    end
`ifdef BOOT_WATCHDOG_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_nxt   = ST_DONE;
                        timeout_nxt = 1'b1;
                        result_nxt  = TIMEOUT_VALUE;
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State plus registered outputs decoded from the next state, so every
    // output changes on the same edge as state_o.
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            state_q              <= ST_IDLE;
            cnt_q                <= '0;
            mode_q               <= '0;
            exit_value_o         <= '0;
            timeout_o            <= 1'b0;
            sys_rst_no           <= 1'b0;
            jtag_trst_no         <= 1'b0;
            boot_select_o        <= 1'b0;
            execute_from_flash_o <= 1'b0;
            busy_o               <= 1'b0;
            done_o               <= 1'b0;
        end else begin
            state_q              <= state_nxt;
            cnt_q                <= cnt_nxt;
            mode_q               <= mode_nxt;
            exit_value_o         <= result_nxt;
            timeout_o            <= timeout_nxt;
            sys_rst_no           <= (state_nxt inside {ST_RELEASE, ST_RUN, ST_DONE});
            jtag_trst_no         <= (state_nxt inside {ST_RELEASE, ST_RUN, ST_DONE});
            boot_select_o        <= (state_nxt != ST_IDLE) && mode_nxt.boot_select;
            execute_from_flash_o <= (state_nxt != ST_IDLE) && mode_nxt.execute_from_flash;
            busy_o               <= (state_nxt inside {ST_ASSERT, ST_RELEASE, ST_RUN});
            done_o               <= (state_nxt == ST_DONE);
        end
    end

    assign state_o = state_q;

`ifndef BOOT_WATCHDOG_EN
    // Watchdog configuration has no effect in this build.
    logic unused_watchdog_cfg;
    assign unused_watchdog_cfg = ^{TIMEOUT_CYCLES, TIMEOUT_VALUE};
`endif

endmodule
